data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder serving the multi-cycle core's load/store and fetch requests.
//  Accepts one request via valid/ready, inserts configurable wait states, then performs the access.
//  Access is a byte-laned write or a sign/zero-extended read on an internal word array.
//  Returns one response via valid/ready. Sits between the core datapath/FSM and on-chip data RAM.
// PARAMETERS
//  ADDR_WIDTH   10  word-address width; array depth = 2**ADDR_WIDTH words
//  DATA_WIDTH   32  word width; fixed at 32 (RV32 load/store semantics)
//  WAIT_STATES  2   idle cycles between request accept and array access; 0..15
// PORTS
//  clk            in   1   clock, rising edge
//  arstn          in   1   asynchronous active-low reset
//  i_req_valid    in   1   request present
//  o_req_ready    out  1   responder can accept (high only in IDLE)
//  i_req_write    in   1   1 = store, 0 = load
//  i_req_addr     in   32  byte address
//  i_req_func_3   in   3   RV32 funct3 (access size / signedness)
//  i_req_wdata    in   32  store data, right-aligned (byte/half in LSBs)
//  o_resp_valid   out  1   response present
//  i_resp_ready   in   1   requester consumes response
//  o_resp_rdata   out  32  load result, extended; 0 for stores and errors
//  o_resp_err     out  1   access rejected (no array side effect)
// BEHAVIOUR
//  Reset (arstn low, async): state=IDLE; o_req_ready=0, o_resp_valid=0, o_resp_rdata=0, o_resp_err=0.
//    o_req_ready rises the first cycle after reset release. Array contents are not reset (undefined).
//  FSM states: IDLE -> WAIT -> ACCESS -> RESP -> IDLE.
//    IDLE: ready=1; on valid&ready, capture write/addr/func_3/wdata.
//      Load wait counter = WAIT_STATES. Go to WAIT, or to ACCESS if WAIT_STATES==0.
//    WAIT: counter decrements each cycle; go to ACCESS in the cycle the counter reads 1.
//    ACCESS: single cycle. Array write happens on this cycle's edge; read data is registered.
//    RESP: resp_valid=1; rdata/err held stable until i_resp_ready; then go to IDLE (ready next cycle).
//  Latency: handshake in cycle N -> o_resp_valid first high in cycle N+WAIT_STATES+2.
//    Back-to-back throughput: one request per WAIT_STATES+3 cycles.
//  Inputs are ignored outside IDLE; captured fields do not change until return to IDLE.
//  Store funct3: 000 SB (1 lane at addr[1:0]), 001 SH (lanes addr[1]*2 +0/+1), 010 SW (all lanes).
//  Load funct3: 000 LB sext8, 001 LH sext16, 010 LW, 100 LBU zext8, 101 LHU zext16.
//  Error (err=1, no write, rdata=0):
//    - undefined funct3 for the direction (store 011..111; load 011, 110, 111);
//    - out of range: addr[31:ADDR_WIDTH+2] != 0.
//    - Word index = addr[ADDR_WIDTH+1:2]; wrap-around is never silent (out of range -> err).
//  Reset mid-operation: any state returns to IDLE.
//    A store not yet at its ACCESS edge is not performed. A pending response is dropped.
//  Simultaneous i_req_valid in RESP: ignored; accepted only once back in IDLE.
// CONFIGURATION
//  Macro DATA_MEM_RESP_MISALIGN_ERR_EN:
//    defined: misaligned access is an error (SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0).
//      err=1, no write, rdata=0.
//    undefined: misaligned addresses are aligned down to access size (addr[0], or addr[1:0], forced 0).
//      The access proceeds; err only for funct3/range.
// STRUCTURE
//  Package data_mem_resp_pkg: state enum (IDLE/WAIT/ACCESS/RESP), funct3 localparams
//    (F3_B/H/W/BU/HU), WAIT counter width constant.
//  Sub-module ls_lane_aligner (combinational):
//    func_3 + addr[1:0] + wdata -> 4-bit byte strobe + lane-shifted wdata;
//    raw word -> extended rdata; also flags misalign/invalid funct3.
//  Top holds the FSM, capture registers, wait counter, response registers and the word array.
// TESTING (WAIT_STATES=2 unless noted)
//  1. Reset release -> o_req_ready=1 next cycle; resp_valid=0, rdata=0, err=0.
//  2. SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, err=0.
//     resp_valid in cycle N+4 after each handshake.
//  3. SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080;
//     LW @0x20 shows only byte1 changed.
//  4. LH @0x13:
//     macro on -> err=1, rdata=0;
//     macro off -> same result as LH @0x12.
//  5. Store @0x00001000 (ADDR_WIDTH=10) -> err=1; subsequent LW @0x0 unchanged.
//     Store funct3=011 -> err=1.
//  6. Hold i_resp_ready=0 for 5 cycles in RESP -> rdata/err stable, req_ready=0.
//     Assert arstn=0 during WAIT of an SW -> IDLE, later LW shows old data.
//     WAIT_STATES=0 -> resp_valid in cycle N+2.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data memory responder.
package data_mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Wide enough for WAIT_STATES up to 15.
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/data_mem_responder_ls_lane_aligner.sv
// Byte-lane steering for RV32 loads/stores: strobes, lane-replicated store data, load extension.
// DATA_MEM_RESP_MISALIGN_ERR_EN: when defined, misaligned half/word accesses raise o_bad.
module ls_lane_aligner
   import data_mem_resp_pkg::*;
(
   input  logic        i_write,
   input  logic [2:0]  i_func_3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_raw_word,
   output logic [3:0]  o_strb,
   output logic [31:0] o_wdata_lane,
   output logic [31:0] o_rdata,
   output logic        o_bad
);

   logic [1:0]  w_off;
   logic        w_f3_bad;
   logic [31:0] w_shifted;

   // Offsets are aligned down to the access size; misalignment is flagged separately.
   always_comb begin
      w_off        = 2'b00;
      o_strb       = 4'b1111;
      o_wdata_lane = i_wdata;
      case (i_func_3[1:0])
         2'b00: begin
            w_off        = i_addr_lo;
            o_strb       = 4'b0001 << i_addr_lo;
            o_wdata_lane = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_off        = {i_addr_lo[1], 1'b0};
            o_strb       = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata_lane = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_f3_bad = 1'b1;
      if (i_write) begin
         w_f3_bad = (i_func_3 > F3_W);
      end else begin
         case (i_func_3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: w_f3_bad = 1'b0;
            default:                        w_f3_bad = 1'b1;
         endcase
      end
   end

   assign w_shifted = i_raw_word >> {w_off, 3'b000};

   always_comb begin
      case (i_func_3)
         F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_BU:   o_rdata = {24'h000000, w_shifted[7:0]};
         F3_HU:   o_rdata = {16'h0000, w_shifted[15:0]};
         default: o_rdata = w_shifted;
      endcase
   end

`ifdef DATA_MEM_RESP_MISALIGN_ERR_EN
   logic w_misalign;
   assign w_misalign = (i_func_3[1:0] == 2'b00) ? 1'b0 :
                       (i_func_3[1:0] == 2'b01) ? i_addr_lo[0] : (|i_addr_lo);
   assign o_bad = w_f3_bad | w_misalign;
`else
   assign o_bad = w_f3_bad;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES idle cycles, then array access and response.
// Misalign error behaviour is selected by DATA_MEM_RESP_MISALIGN_ERR_EN (see ls_lane_aligner).
//   state  | meaning
//   IDLE   | ready for a request; captures it on handshake
//   WAIT   | counting down wait states
//   ACCESS | array write / read happens on this cycle's edge
//   RESP   | response held until i_resp_ready
module data_mem_responder
   import data_mem_resp_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [31:0]           i_req_addr,
   input  logic [2:0]            i_req_func_3,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_resp_valid,
   input  logic                  i_resp_ready,
   output logic [DATA_WIDTH-1:0] o_resp_rdata,
   output logic                  o_resp_err
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

   state_t                  r_state, w_next;
   logic                    r_rst_done;
   logic                    r_write;
   logic [31:0]             r_addr;
   logic [2:0]              r_func_3;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [WAIT_CNT_W-1:0]   r_cnt;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_err;
   logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_WIDTH];

   logic                    w_accept;
   logic                    w_mem_we;
   logic [ADDR_WIDTH-1:0]   w_idx;
   logic                    w_range_err;
   logic                    w_bad;
   logic                    w_err;
   logic [3:0]              w_strb;
   logic [DATA_WIDTH-1:0]   w_wdata_lane;
   logic [DATA_WIDTH-1:0]   w_rdata;

   assign w_idx       = r_addr[ADDR_WIDTH+1:2];
   assign w_range_err = |r_addr[31:ADDR_WIDTH+2];
   assign w_err       = w_range_err | w_bad;
   assign w_accept    = i_req_valid & o_req_ready;

   ls_lane_aligner u_aligner (
      .i_write      (r_write),
      .i_func_3     (r_func_3),
      .i_addr_lo    (r_addr[1:0]),
      .i_wdata      (r_wdata),
      .i_raw_word   (r_mem[w_idx]),
      .o_strb       (w_strb),
      .o_wdata_lane (w_wdata_lane),
      .o_rdata      (w_rdata),
      .o_bad        (w_bad)
   );

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_state    <= IDLE;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_rst_done <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = (WAIT_STATES == 0) ? ACCESS : WAIT;
         WAIT:    if (r_cnt == WAIT_CNT_W'(1)) w_next = ACCESS;
         ACCESS:  w_next = RESP;
         RESP:    if (i_resp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Ready is held low for the first cycle out of reset.
   always_comb begin
      o_req_ready  = (r_state == IDLE) && r_rst_done;
      o_resp_valid = (r_state == RESP);
      w_mem_we     = (r_state == ACCESS) && r_write && !w_err;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_func_3 <= '0;
         r_wdata  <= '0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_write  <= i_req_write;
         r_addr   <= i_req_addr;
         r_func_3 <= i_req_func_3;
         r_wdata  <= i_req_wdata;
         r_cnt    <= WAIT_LOAD;
      end else if (r_state == WAIT) begin
         r_cnt    <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (r_state == ACCESS) begin
         r_err   <= w_err;
         r_rdata <= (r_write || w_err) ? '0 : w_rdata;
      end else if ((r_state == RESP) && i_resp_ready) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_lane[8*i +: 8];
         end
      end
   end

   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a byte-level memory model; also runs a WAIT_STATES=0 copy in lockstep.
module tb_data_mem_responder;

   localparam int AW = 10;
   localparam int WS = 2;
   localparam int MEM_BYTES = 4 * (1 << AW);

   logic        clk = 1'b0;
   logic        arstn;
   logic        i_req_valid, i_req_write, i_resp_ready;
   logic [31:0] i_req_addr, i_req_wdata;
   logic [2:0]  i_req_func_3;
   logic        o_req_ready, o_resp_valid, o_resp_err;
   logic [31:0] o_resp_rdata;
   logic        rdy0, vld0, err0;
   logic [31:0] rd0;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut (
      .clk(clk), .arstn(arstn), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_func_3(i_req_func_3),
      .i_req_wdata(i_req_wdata), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
      .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err)
   );

   data_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
      .clk(clk), .arstn(arstn), .i_req_valid(i_req_valid), .o_req_ready(rdy0),
      .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_func_3(i_req_func_3),
      .i_req_wdata(i_req_wdata), .o_resp_valid(vld0), .i_resp_ready(i_resp_ready),
      .o_resp_rdata(rd0), .o_resp_err(err0)
   );

   int          cyc = 0;
   int          n_vec = 0, n_err = 0;
   bit          busy = 1'b0, rstdone = 1'b0;
   int          exp_start = 0, exp_start0 = 0;
   logic [31:0] exp_rd = '0;
   logic        exp_err = 1'b0;
   byte unsigned mem_b [MEM_BYTES];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Specification-level model: byte-addressed memory, size/sign from funct3.
   function automatic void model(input logic w, input logic [31:0] a, input logic [2:0] f3,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic err);
      int          size;
      bit          sgn, bad;
      logic [31:0] v, ea;
      size = 0; sgn = 0; bad = 0; rd = '0; err = 1'b0; v = '0; ea = a;
      if (w) begin
         case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            default: bad = 1;
         endcase
      end else begin
         case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: bad = 1;
         endcase
      end
      if (a > 32'(MEM_BYTES - 1)) bad = 1;
      if (!bad && (a % size) != 0) begin
`ifdef DATA_MEM_RESP_MISALIGN_ERR_EN
         bad = 1;
`else
         ea = a - (a % size);
`endif
      end
      if (bad) begin
         err = 1'b1;
         return;
      end
      if (w) begin
         for (int i = 0; i < size; i++) mem_b[ea + i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < size; i++) v[8*i +: 8] = mem_b[ea + i];
         if (sgn && v[8*size-1]) for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
         rd = v;
      end
   endfunction

   always @(posedge clk) begin
      logic er, ev, ev0;
      #1;
      er  = rstdone && !busy;
      ev  = busy && (cyc >= exp_start);
      ev0 = busy && (cyc >= exp_start0);
      chk("req_ready", o_req_ready, er);
      chk("req_ready_ws0", rdy0, er);
      chk("resp_valid", o_resp_valid, ev);
      chk("resp_valid_ws0", vld0, ev0);
      if (ev) begin
         chk("resp_rdata", o_resp_rdata, exp_rd);
         chk("resp_err", o_resp_err, exp_err);
      end
      if (ev0) begin
         chk("resp_rdata_ws0", rd0, exp_rd);
         chk("resp_err_ws0", err0, exp_err);
      end
   end

   task automatic req(input logic w, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                      input int hold, input logic [31:0] lit_rd, input logic lit_err, input string nm);
      int n, t;
      @(negedge clk);
      i_req_valid = 1'b1; i_req_write = w; i_req_addr = a; i_req_func_3 = f3; i_req_wdata = wd;
      t = 0;
      while (!o_req_ready && t < 100) begin @(negedge clk); t++; end
      if (!o_req_ready) begin
         chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
         i_req_valid = 1'b0;
         return;
      end
      n = cyc;
      model(w, a, f3, wd, exp_rd, exp_err);
      exp_start  = n + WS + 2;
      exp_start0 = n + 2;
      @(posedge clk);
      busy = 1'b1;
      @(negedge clk);
      i_req_valid = 1'b0; i_req_write = ~w; i_req_addr = 32'hFFFF_FFFF;
      i_req_func_3 = 3'b111; i_req_wdata = 32'h5A5A_5A5A;
      while (cyc < exp_start) @(negedge clk);
      chk({nm, "_lit_rdata"}, o_resp_rdata, lit_rd);
      chk({nm, "_lit_err"}, o_resp_err, lit_err);
      if (hold > 0) begin
         // A competing store arrives while the response is held; it must be ignored.
         i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 32'h0;
         i_req_func_3 = 3'b010; i_req_wdata = 32'hFFFF_FFFF;
         repeat (hold) @(negedge clk);
         i_req_valid = 1'b0;
      end
      i_resp_ready = 1'b1;
      @(posedge clk);
      busy = 1'b0;
      @(negedge clk);
      i_resp_ready = 1'b0;
   endtask

   task automatic abort_sw();
      int t;
      @(negedge clk);
      i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 32'h10;
      i_req_func_3 = 3'b010; i_req_wdata = 32'h5555_5555;
      t = 0;
      while (!o_req_ready && t < 100) begin @(negedge clk); t++; end
      if (!o_req_ready) begin
         chk("abort_ready_timeout", 32'd0, 32'd1);
         i_req_valid = 1'b0;
         return;
      end
      exp_start  = cyc + WS + 2;
      exp_start0 = cyc + 2;
      @(posedge clk);
      busy = 1'b1;
      @(negedge clk);
      i_req_valid = 1'b0;
      arstn = 1'b0; busy = 1'b0; rstdone = 1'b0;
      #1;
      chk("abort_ready", o_req_ready, 1'b0);
      chk("abort_valid", o_resp_valid, 1'b0);
      chk("abort_rdata", o_resp_rdata, 32'h0);
      chk("abort_err", o_resp_err, 1'b0);
      repeat (2) @(negedge clk);
      arstn = 1'b1;
      @(posedge clk);
      rstdone = 1'b1;
   endtask

   initial begin
      arstn = 1'b0; i_req_valid = 1'b0; i_req_write = 1'b0; i_resp_ready = 1'b0;
      i_req_addr = '0; i_req_wdata = '0; i_req_func_3 = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", o_req_ready, 1'b0);
      chk("rst_valid", o_resp_valid, 1'b0);
      chk("rst_rdata", o_resp_rdata, 32'h0);
      chk("rst_err", o_resp_err, 1'b0);
      arstn = 1'b1;
      @(posedge clk);
      rstdone = 1'b1;

      req(1, 32'h10, 3'b010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, "sw_10");
      req(0, 32'h10, 3'b010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, "lw_10");

      req(1, 32'h20, 3'b010, 32'h1122_3344, 0, 32'h0, 1'b0, "sw_20");
      req(1, 32'h21, 3'b000, 32'hABCD_EF80, 0, 32'h0, 1'b0, "sb_21");
      req(0, 32'h21, 3'b000, 32'h0, 0, 32'hFFFF_FF80, 1'b0, "lb_21");
      req(0, 32'h21, 3'b100, 32'h0, 0, 32'h0000_0080, 1'b0, "lbu_21");
      req(0, 32'h20, 3'b010, 32'h0, 0, 32'h1122_8044, 1'b0, "lw_20");
      req(0, 32'h22, 3'b001, 32'h0, 0, 32'h0000_1122, 1'b0, "lh_22");
      req(0, 32'h20, 3'b101, 32'h0, 0, 32'h0000_8044, 1'b0, "lhu_20");

      req(0, 32'h12, 3'b001, 32'h0, 0, 32'hFFFF_DEAD, 1'b0, "lh_12");
`ifdef DATA_MEM_RESP_MISALIGN_ERR_EN
      req(0, 32'h13, 3'b001, 32'h0, 0, 32'h0, 1'b1, "lh_13");
`else
      req(0, 32'h13, 3'b001, 32'h0, 0, 32'hFFFF_DEAD, 1'b0, "lh_13");
`endif

      req(1, 32'h0, 3'b010, 32'h0BAD_F00D, 0, 32'h0, 1'b0, "sw_0");
      req(1, 32'h1000, 3'b010, 32'h1234_5678, 0, 32'h0, 1'b1, "sw_oor");
      req(0, 32'h0, 3'b010, 32'h0, 0, 32'h0BAD_F00D, 1'b0, "lw_0_after_oor");
      req(1, 32'h0, 3'b011, 32'hFFFF_FFFF, 0, 32'h0, 1'b1, "st_f3_011");
      req(0, 32'h0, 3'b110, 32'h0, 0, 32'h0, 1'b1, "ld_f3_110");
      req(0, 32'h0, 3'b011, 32'h0, 0, 32'h0, 1'b1, "ld_f3_011");
      req(0, 32'hFFFF_FFFC, 3'b010, 32'h0, 0, 32'h0, 1'b1, "lw_oor");
      req(1, 32'hFFC, 3'b010, 32'hCAFE_F00D, 0, 32'h0, 1'b0, "sw_last");
      req(0, 32'hFFC, 3'b010, 32'h0, 0, 32'hCAFE_F00D, 1'b0, "lw_last");

      req(0, 32'h10, 3'b010, 32'h0, 5, 32'hDEAD_BEEF, 1'b0, "lw_hold");
      abort_sw();
      req(0, 32'h10, 3'b010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, "lw_after_abort");
      req(0, 32'h0, 3'b010, 32'h0, 0, 32'h0BAD_F00D, 1'b0, "lw_0_final");

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
